div_unit: RTL and testbench

//  Iterative 32-bit DIV/DIVU engine for the EX stage; inverse companion of the pipelined multiplier.

---
 rtl/div_unit_pkg.sv | 5 +
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit_sign_fix.sv | 14 +
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared types for the iterative EX-stage divider: FSM state encoding and iteration count.
package div_unit_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
  localparam int DIV_ITERS = 32;
endpackage

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the divider.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic             annul_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             div_stall_o;
  logic             valid_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  div_stall_o, valid_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output div_stall_o, valid_o, quotient_o, remainder_o
  );
endinterface

// File: rtl/div_unit_sign_fix.sv
// Two's-complement magnitude on the way in and conditional negation on the way out.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic                    a_neg_i,
  output logic signed [WIDTH-1:0] a_abs_o,
  input  logic signed [WIDTH-1:0] r_i,
  input  logic                    r_neg_i,
  output logic signed [WIDTH-1:0] r_o
);
  assign a_abs_o = a_neg_i ? -a_i : a_i;
  assign r_o     = r_neg_i ? -r_i : r_i;
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, fixed 33-cycle latency.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DIV_ITERS) + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, dvd_raw_q, dvd_raw_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic             neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, dvz_q, dvz_d;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nx, quot_nx, dvd_abs, dvs_abs, q_fix, r_fix;
  logic             stall, valid, last;

  // Dividend magnitude in, remainder sign out
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_dvd (
    .a_i(bus.dividend_i), .a_neg_i(bus.signed_i & bus.dividend_i[WIDTH-1]), .a_abs_o(dvd_abs),
    .r_i(rem_nx), .r_neg_i(neg_rem_q), .r_o(r_fix)
  );

  // Divisor magnitude in, quotient sign out
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_dvs (
    .a_i(bus.divisor_i), .a_neg_i(bus.signed_i & bus.divisor_i[WIDTH-1]), .a_abs_o(dvs_abs),
    .r_i(quot_nx), .r_neg_i(neg_quot_q), .r_o(q_fix)
  );

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign diff    = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quot_nx = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_nx  = diff[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : diff[WIDTH-1:0];
  assign last    = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    dvd_raw_d  = dvd_raw_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dvz_d      = dvz_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    stall      = 1'b0;
    valid      = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          stall      = 1'b1;
          state_d    = DIV_RUN;
          cnt_d      = '0;
          rem_d      = '0;
          quot_d     = dvd_abs;
          dvs_d      = dvs_abs;
          dvd_raw_d  = bus.dividend_i;
          neg_quot_d = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
          neg_rem_d  = bus.signed_i & bus.dividend_i[WIDTH-1];
          dvz_d      = (bus.divisor_i == '0);
        end
      end
      DIV_RUN: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
          cnt_d   = '0;
        end else begin
          stall  = 1'b1;
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + 1'b1;
          if (last) begin
            state_d = DIV_DONE;
            q_out_d = dvz_q ? '1 : q_fix;
            r_out_d = dvz_q ? dvd_raw_q : r_fix;
          end
        end
      end
      DIV_DONE: begin
        valid   = !bus.annul_i;
        state_d = DIV_IDLE;
        if (bus.annul_i) cnt_d = '0;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rem_q      <= rem_d;
    quot_q     <= quot_d;
    dvs_q      <= dvs_d;
    dvd_raw_q  <= dvd_raw_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
    dvz_q      <= dvz_d;
  end

  assign bus.div_stall_o = stall;
  assign bus.valid_o     = valid;
  assign bus.quotient_o  = q_out_q;
  assign bus.remainder_o = r_out_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: fixed-latency checks with a result scoreboard.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  typedef struct packed {logic [31:0] q; logic [31:0] r;} res_t;
  res_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_q, last_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    res_t e;
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0;
    end else begin
      e.q = sa / sb_; e.r = sa % sb_;
    end
    return e;
  endfunction

  // Caller is positioned just after a negedge; this cycle is acceptance cycle N.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit hold);
    res_t e, got;
    e = model(sgn, a, b);
    sb.push_back(e);
    bus.start_i = 1'b1; bus.signed_i = sgn; bus.dividend_i = a; bus.divisor_i = b;
    #1 chk("stall_accept", bus.div_stall_o, 1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
      #1;
      chk("stall_run", bus.div_stall_o, 1);
      chk("valid_run", bus.valid_o, 0);
      if (k == 32) begin
        chk("q_held", bus.quotient_o, last_q);
        chk("r_held", bus.remainder_o, last_r);
      end
    end
    @(negedge clk);
    if (!hold) bus.start_i = 1'b0;
    #1;
    chk("valid_done", bus.valid_o, 1);
    chk("stall_done", bus.div_stall_o, 0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("quotient", bus.quotient_o, got.q);
      chk("remainder", bus.remainder_o, got.r);
    end
    last_q = e.q;
    last_r = e.r;
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    chk("valid_after", bus.valid_o, 0);
    chk("stall_after", bus.div_stall_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
    bus.dividend_i = '0; bus.divisor_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_q", bus.quotient_o, 0);
    chk("rst_r", bus.remainder_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_stall", bus.div_stall_o, 0);
    last_q = '0; last_r = '0;
    rst = 1'b0;

    @(negedge clk); run_div(1'b0, 32'd100, 32'd7, 1'b0);
    @(negedge clk); run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk); run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk); run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk); run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clk); run_div(1'b0, 32'd5, 32'd0, 1'b0);
    @(negedge clk); run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // Annul at RUN cycle 10, then a back-to-back divide in the following cycle
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    chk("annul_stall", bus.div_stall_o, 0);
    chk("annul_valid", bus.valid_o, 0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_q_held", bus.quotient_o, last_q);
    chk("annul_r_held", bus.remainder_o, last_r);
    run_div(1'b0, 32'd9, 32'd3, 1'b0);

    // Reset at RUN cycle 20
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_i = 1'b1; bus.dividend_i = 32'hFFFF_FFF9; bus.divisor_i = 32'd2;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_q", bus.quotient_o, 0);
    chk("midrst_r", bus.remainder_o, 0);
    chk("midrst_valid", bus.valid_o, 0);
    chk("midrst_stall", bus.div_stall_o, 0);
    rst = 1'b0;
    last_q = '0; last_r = '0;

    // start_i held through DONE must give a single valid pulse
    @(negedge clk); run_div(1'b0, 32'd1000, 32'd10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("post_hold_valid", bus.valid_o, 0);
      chk("post_hold_stall", bus.div_stall_o, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
